// File: rtl/twos_to_float_pkg.sv
// twos_to_float_pkg: shared widths and types for the twos-to-float converter.
package twos_to_float_pkg;
    localparam int MAG_W   = 11;
    localparam int EXP_W   = 3;
    localparam int SIG_W   = 4;
    localparam int CNT_SAT = 2**EXP_W - 1;
    typedef logic [MAG_W-1:0] mag_t;
    typedef logic [EXP_W-1:0] lzc_t;
endpackage

// File: rtl/lzc_comb.sv
// lzc_comb: combinational priority scan from the MSB, giving the unsaturated count and a zero flag.
module lzc_comb #(
    parameter int IN_W      = 11,
    parameter int LZ_OFFSET = 1,
    parameter int RAW_W     = 4
) (
    input  logic [IN_W-1:0]  in,
    output logic [RAW_W-1:0] raw,
    output logic             zero
);
    // Scanning upward lets the highest set bit be the last assignment, so it wins.
    always_comb begin
        raw = RAW_W'(LZ_OFFSET + IN_W);
        for (int i = 0; i < IN_W; i++)
            if (in[i]) raw = RAW_W'(LZ_OFFSET + IN_W - 1 - i);
    end
    assign zero = ~|in;
endmodule

// File: rtl/priority_encoder_lzc.sv
// priority_encoder_lzc: registered, saturating leading-zero count of the magnitude field.
// Define PRIORITY_ENCODER_ONEHOT_EN to add a registered one-hot leading-one output.
module priority_encoder_lzc
    import twos_to_float_pkg::*;
#(
    parameter int IN_W      = MAG_W,
    parameter int CNT_W     = EXP_W,
    parameter int LZ_OFFSET = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    output logic [CNT_W-1:0] out,
    output logic             zero
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    ,
    output logic [IN_W-1:0]  onehot
`endif
);
    localparam int RAW_W = $clog2(LZ_OFFSET + IN_W + 1);
    localparam int SAT   = 2**CNT_W - 1;
    logic [RAW_W-1:0] w_raw;
    logic             w_zero;
    logic [CNT_W-1:0] w_cnt;
    logic             r_valid;
    logic [CNT_W-1:0] r_out;
    logic             r_zero;
    lzc_comb #(.IN_W(IN_W), .LZ_OFFSET(LZ_OFFSET), .RAW_W(RAW_W)) u_lzc (
        .in   (in),
        .raw  (w_raw),
        .zero (w_zero)
    );
    assign w_cnt = (int'(w_raw) > SAT) ? CNT_W'(SAT) : CNT_W'(w_raw);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out  <= w_cnt;
                r_zero <= w_zero;
            end
        end
    end
    assign out_valid = r_valid;
    assign out       = r_out;
    assign zero      = r_zero;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [IN_W-1:0] w_onehot;
    logic [IN_W-1:0] r_onehot;
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < IN_W; i++)
            if (in[i]) w_onehot = IN_W'(1) << i;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_onehot <= '0;
        else if (in_valid) r_onehot <= w_onehot;
    end
    assign onehot = r_onehot;
`endif
endmodule

// File: tb/tb_priority_encoder_lzc.sv
// tb_priority_encoder_lzc: table-driven check of the registered leading-zero counter.
module tb_priority_encoder_lzc;
    import twos_to_float_pkg::*;
    typedef struct {
        logic [10:0] in;
        logic [2:0]  cnt;
        logic        z;
        logic [10:0] oh;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [10:0] in_d = '0;
    logic        out_valid;
    lzc_t        out;
    logic        zero;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[10];
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [10:0] onehot;
`endif
    priority_encoder_lzc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_d),
        .out_valid (out_valid),
        .out       (out),
        .zero      (zero)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        ,
        .onehot    (onehot)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_all(input string name, input logic v, input logic [2:0] c, input logic z, input logic [10:0] oh);
        chk({name, " out_valid"}, int'(out_valid), int'(v));
        chk({name, " out"}, int'(out), int'(c));
        chk({name, " zero"}, int'(zero), int'(z));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        chk({name, " onehot"}, int'(onehot), int'(oh));
`else
        if (oh === 11'h7FF) $display("unreachable");
`endif
    endtask
    initial begin
        vecs[0] = '{11'h400, 3'd1, 1'b0, 11'h400};
        vecs[1] = '{11'h080, 3'd4, 1'b0, 11'h080};
        vecs[2] = '{11'h040, 3'd5, 1'b0, 11'h040};
        vecs[3] = '{11'h7FF, 3'd1, 1'b0, 11'h400};
        vecs[4] = '{11'h010, 3'd7, 1'b0, 11'h010};
        vecs[5] = '{11'h001, 3'd7, 1'b0, 11'h001};
        vecs[6] = '{11'h000, 3'd7, 1'b1, 11'h000};
        vecs[7] = '{11'h020, 3'd6, 1'b0, 11'h020};
        vecs[8] = '{11'h100, 3'd3, 1'b0, 11'h100};
        vecs[9] = '{11'h200, 3'd2, 1'b0, 11'h200};
        #1;
        chk_all("reset", 1'b0, 3'd0, 1'b0, 11'h000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_d = vecs[i].in;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].cnt, vecs[i].z, vecs[i].oh);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_d = 11'h7FF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("hold%0d", i), 1'b0, 3'd2, 1'b0, 11'h200);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_d = 11'h080;
        @(posedge clk);
        #1;
        chk_all("pre_reset", 1'b1, 3'd4, 1'b0, 11'h080);
        in_d = 11'h7FF;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 3'd0, 1'b0, 11'h000);
        @(posedge clk);
        #1;
        chk_all("in_reset", 1'b0, 3'd0, 1'b0, 11'h000);
        @(negedge clk);
        reset = 1'b0;
        in_d = 11'h100;
        @(posedge clk);
        #1;
        chk_all("post_reset", 1'b1, 3'd3, 1'b0, 11'h100);
        @(negedge clk);
        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/priority_encoder_lzc.md
Name: priority_encoder_lzc

Overview:
- Registered leading-zero counter for the magnitude field of the twos-to-float converter.
- Takes the 11-bit magnitude, with the sign bit already stripped, and reports how many zeros precede the leading one in the implied 12-bit word (implicit zero sign bit included), saturated to 3 bits.
- The downstream extractor uses the count directly:
  - exponent = 8 − count
  - significand = in[11−count : 8−count]
  - rounding bit = in[7−count]

Parameters:
- IN_W, 11, magnitude width in bits.
- CNT_W, 3, count width; the count saturates at 2^CNT_W−1.
- LZ_OFFSET, 1, implicit leading zeros added to the count (the stripped sign bit).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in for capture this cycle.
- in  in  IN_W  unsigned magnitude X[10:0].
- out_valid  out  1  out/zero are valid this cycle.
- out  out  CNT_W  saturated leading-zero count (nZeroes).
- zero  out  1  in was all zeros.

Behaviour:
- Count definition:
  - raw = LZ_OFFSET + (number of consecutive zeros in in[IN_W−1] downward before the first 1).
  - For in == 0, raw = LZ_OFFSET + IN_W.
  - out = min(raw, 2^CNT_W−1).
- Default mapping:
  - in[10]=1 → 1; in[9] is the leading one → 2; … in[5] → 6.
  - Leading one at in[4] or lower, or in == 0 → 7.
- Saturated codes never let the extractor index below bit 0, because 7−7=0.
- zero = (in == 0), independent of saturation.
- Latency: exactly 1 clock.
  - On a rising clk with in_valid=1: register out, zero, and set out_valid=1.
  - With in_valid=0: out_valid goes to 0 and out/zero hold their last values.
- No backpressure. Back-to-back in_valid is accepted every cycle at full throughput.
- Reset, asynchronous and immediate, including mid-stream:
  - out_valid=0, out=0, zero=0.
  - Inputs are ignored while reset is high.
  - The first capture happens on the first rising clk after reset deasserts.
- X/Z on in while in_valid=0 must not propagate to out.
- Combinational core is a pure priority scan from MSB; no latches, no loops with data-dependent bounds.

Optional Feature:
- Macro PRIORITY_ENCODER_ONEHOT_EN.
- When defined:
  - Adds output port onehot [IN_W−1:0], registered with the same timing as out.
  - onehot holds a single 1 at the position of the leading one of in; all zeros when in==0.
  - Reset value of onehot is 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package twos_to_float_pkg:
  - MAG_W=11, EXP_W=3, SIG_W=4.
  - CNT_SAT = 2^EXP_W−1.
  - Typedef mag_t for the magnitude, typedef lzc_t for the count.
- One natural combinational sub-module, lzc_comb: in → raw count and zero flag.
- The top adds saturation, the registers, and the optional onehot.

Test Plan:
- in=11'h400, in_valid=1 → next cycle out=1, zero=0, out_valid=1.
- in=11'h080 → out=4; in=11'h040 → out=5; in=11'h7FF → out=1, back-to-back cycles, each result exactly one cycle after its input.
- in=11'h010 → out=7 (raw 7); in=11'h001 → out=7 (raw 11, saturated); zero=0 for both.
- in=11'h000 → out=7, zero=1; with the macro defined, onehot=0. in=11'h080 with the macro → onehot=11'h080.
- in_valid=0 for 3 cycles after in=11'h200 → out_valid=0, out holds 2.
- Assert reset mid-stream between clock edges → out_valid/out/zero drop to 0 immediately. After release, in=11'h100 → out=3.
